// File: rtl/regfile_seq_ctrl.sv
// rtl/regfile_seq_ctrl.sv - register-file sequence generator FSM; optional overflow detect via SEQ_OVF_DETECT_EN
module regfile_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int SEED0  = 1,
    parameter int SEED1  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED0,
        S_SEED1,
        S_READ,
        S_CALC,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(2);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;
    logic              run_accept;

    assign run_accept = (state == S_IDLE) && (state_nxt == S_SEED0);

    // State and index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= FIRST_IDX;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state and next-index decode; abort overrides everything outside IDLE
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nxt = S_SEED0;
                    idx_nxt   = FIRST_IDX;
                end
            end
            S_SEED0: state_nxt = S_SEED1;
            S_SEED1: state_nxt = S_READ;
            S_READ:  state_nxt = S_CALC;
            S_CALC:  state_nxt = S_WRITE;
            S_WRITE: begin
                if (idx == LAST_IDX) begin
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt   = idx + 1'b1;
                    state_nxt = S_READ;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            idx_nxt   = idx;
        end
    end

    // Registered outputs, decoded from the state being entered so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            rf_we     <= 1'b0;
            rf_raddr1 <= '0;
            rf_raddr2 <= '0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= 2'b00;
        end else begin
            busy  <= (state_nxt == S_SEED0) || (state_nxt == S_SEED1) || (state_nxt == S_READ) ||
                     (state_nxt == S_CALC) || (state_nxt == S_WRITE);
            done  <= (state_nxt == S_DONE);
            rf_we <= (state_nxt == S_SEED0) || (state_nxt == S_SEED1) || (state_nxt == S_WRITE);
            case (state_nxt)
                S_SEED0: begin
                    rf_waddr <= '0;
                    rf_wdata <= DATA_W'(SEED0);
                end
                S_SEED1: begin
                    rf_waddr <= ADDR_W'(1);
                    rf_wdata <= DATA_W'(SEED1);
                end
                S_READ: begin
                    rf_raddr1 <= idx_nxt - ADDR_W'(2);
                    rf_raddr2 <= idx_nxt - ADDR_W'(1);
                end
                S_WRITE: rf_waddr <= idx_nxt;
                default: ;
            endcase
            if (run_accept) begin
                alu_op <= mode;
            end
            if (state == S_READ) begin
                alu_a <= rf_rdata1;
                alu_b <= rf_rdata2;
            end
            if (state == S_CALC) begin
                rf_wdata <= alu_out;
            end
        end
    end

`ifdef SEQ_OVF_DETECT_EN
    logic sign_a;
    logic sign_b;
    logic sign_r;
    logic ovf_hit;

    assign sign_a = alu_a[DATA_W-1];
    assign sign_b = alu_b[DATA_W-1];
    assign sign_r = alu_out[DATA_W-1];

    // Signed overflow of the current ALU result; logical ops never overflow
    always_comb begin
        ovf_hit = 1'b0;
        case (alu_op)
            2'b00:   ovf_hit = (sign_a == sign_b) && (sign_r != sign_a);
            2'b01:   ovf_hit = (sign_a != sign_b) && (sign_r != sign_a);
            default: ovf_hit = 1'b0;
        endcase
    end

    // Sticky overflow flag, cleared only when a new run is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (run_accept) begin
            ovf <= 1'b0;
        end else if ((state == S_CALC) && ovf_hit) begin
            ovf <= 1'b1;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// tb/tb_regfile_seq_ctrl.sv - self-checking bench for regfile_seq_ctrl
module tb_regfile_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic        busy, done, ovf, rf_we;
    logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic [31:0] rf_rdata1, rf_rdata2, rf_wdata, alu_a, alu_b, alu_out;
    logic [1:0]  alu_op;

    logic        start_8;
    logic        abort_8;
    logic [1:0]  mode_8;
    logic        busy_8, done_8, ovf_8, rf_we_8;
    logic [3:0]  rf_raddr1_8, rf_raddr2_8, rf_waddr_8;
    logic [7:0]  rf_rdata1_8, rf_rdata2_8, rf_wdata_8, alu_a_8, alu_b_8, alu_out_8;
    logic [1:0]  alu_op_8;

    logic [31:0] rf32 [32];
    logic [7:0]  rf8 [16];
    logic        fill32;
    logic [31:0] fill_base;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_rf [32];
    logic        exp_ovf;

    function automatic logic [31:0] alu_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] mask);
        case (op)
            2'b00:   return (a + b) & mask;
            2'b01:   return (a - b) & mask;
            2'b10:   return a & b & mask;
            default: return (a | b) & mask;
        endcase
    endfunction

    function automatic logic signed_ovf(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input int width);
        longint lim, sa, sb, r;
        lim = longint'(1) << (width - 1);
        sa  = {32'd0, a};
        sb  = {32'd0, b};
        if (sa >= lim) sa = sa - 2 * lim;
        if (sb >= lim) sb = sb - 2 * lim;
        case (op)
            2'b00:   r = sa + sb;
            2'b01:   r = sa - sb;
            default: return 1'b0;
        endcase
        return (r >= lim) || (r < -lim);
    endfunction

    assign rf_rdata1   = rf32[rf_raddr1];
    assign rf_rdata2   = rf32[rf_raddr2];
    assign alu_out     = alu_f(alu_op, alu_a, alu_b, 32'hFFFF_FFFF);
    assign rf_rdata1_8 = rf8[rf_raddr1_8];
    assign rf_rdata2_8 = rf8[rf_raddr2_8];
    assign alu_out_8   = 8'(alu_f(alu_op_8, {24'd0, alu_a_8}, {24'd0, alu_b_8}, 32'h0000_00FF));

    // Behavioural register files; fill32 preloads a random pattern between runs
    always @(posedge clk) begin
        if (fill32) begin
            for (int k = 0; k < 32; k++) rf32[k] <= fill_base ^ 32'(k);
        end else if (rf_we) begin
            rf32[rf_waddr] <= rf_wdata;
        end
        if (rf_we_8) rf8[rf_waddr_8] <= rf_wdata_8;
    end

    regfile_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .busy(busy), .done(done), .ovf(ovf),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out)
    );

    regfile_seq_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_8), .abort(abort_8), .mode(mode_8),
        .busy(busy_8), .done(done_8), .ovf(ovf_8),
        .rf_raddr1(rf_raddr1_8), .rf_raddr2(rf_raddr2_8), .rf_rdata1(rf_rdata1_8), .rf_rdata2(rf_rdata2_8),
        .rf_we(rf_we_8), .rf_waddr(rf_waddr_8), .rf_wdata(rf_wdata_8),
        .alu_a(alu_a_8), .alu_b(alu_b_8), .alu_op(alu_op_8), .alu_out(alu_out_8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference sequence: seeds, then reg[k] = reg[k-2] op reg[k-1]; reg k lands in cycle 3k-1
    task automatic build_model(input logic [1:0] m, input int width, input int depth, input int abort_c,
                               input logic [31:0] fill);
        logic [31:0] mask;
        logic [31:0] v [32];
        int          wc;
        mask    = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        exp_ovf = 1'b0;
        v[0]    = 32'd1 & mask;
        v[1]    = 32'd1 & mask;
        for (int k = 2; k < 32; k++) begin
            v[k] = (k < depth) ? alu_f(m, v[k-2], v[k-1], mask) : 32'd0;
`ifdef SEQ_OVF_DETECT_EN
            if (k < depth && (abort_c == 0 || 3 * k - 2 <= abort_c) && signed_ovf(m, v[k-2], v[k-1], width))
                exp_ovf = 1'b1;
`endif
        end
        for (int k = 0; k < 32; k++) begin
            wc = (k < 2) ? k + 1 : 3 * k - 1;
            exp_rf[k] = (k < depth && (abort_c == 0 || wc <= abort_c)) ? v[k] : (fill ^ 32'(k));
        end
    endtask

    // One run on the 32-bit instance; abort_c=0 means no abort, extra adds ignored start pulses
    task automatic run32(input logic [1:0] m, input int abort_c, input bit extra, input string tag);
        int   done_c, done_n, busy_err, we_err;
        logic exp_busy, exp_we;
        fill_base = $urandom;
        @(negedge clk) fill32 = 1'b1;
        @(negedge clk) fill32 = 1'b0;
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        done_c   = 0;
        done_n   = 0;
        busy_err = 0;
        we_err   = 0;
        for (int c = 1; c <= 96; c++) begin
            if (done) begin
                done_n++;
                done_c = c;
            end
            exp_busy = (c <= 92) && (abort_c == 0 || c <= abort_c);
            exp_we   = (c == 1 || c == 2 || (c >= 5 && c <= 92 && (c - 5) % 3 == 0)) &&
                       (abort_c == 0 || c <= abort_c);
            if (busy !== exp_busy) busy_err++;
            if (rf_we !== exp_we) we_err++;
            abort = (c == abort_c);
            if (extra && (abort_c == 0 || c < abort_c) && c <= 88 && $urandom_range(0, 7) == 0) begin
                start = 1'b1;
                mode  = 2'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        start = 1'b0;
        build_model(m, 32, 32, abort_c, fill_base);
        check({tag, " done_cycle"}, 64'(done_c), 64'((abort_c == 0) ? 93 : 0));
        check({tag, " done_pulses"}, 64'(done_n), 64'((abort_c == 0) ? 1 : 0));
        check({tag, " busy_profile_errs"}, 64'(busy_err), 64'd0);
        check({tag, " we_profile_errs"}, 64'(we_err), 64'd0);
        check({tag, " ovf"}, {63'd0, ovf}, {63'd0, exp_ovf});
        for (int k = 0; k < 32; k++)
            check($sformatf("%s reg%0d", tag, k), {32'd0, rf32[k]}, {32'd0, exp_rf[k]});
    endtask

    // One full run on the 8-bit instance with an optional overflow watch around reg11
    task automatic run8(input logic [1:0] m, input string tag);
        int   done_c;
        logic ovf_pre, ovf_post;
        mode_8  = m;
        start_8 = 1'b1;
        @(negedge clk);
        start_8 = 1'b0;
        done_c  = 0;
        ovf_pre  = 1'b0;
        ovf_post = 1'b0;
        for (int c = 1; c <= 48; c++) begin
            if (done_8) done_c = c;
            if (c == 1) check({tag, " ovf_cleared_on_start"}, {63'd0, ovf_8}, 64'd0);
            if (c == 31) ovf_pre = ovf_8;
            if (c == 32) ovf_post = ovf_8;
            @(negedge clk);
        end
        build_model(m, 8, 16, 0, 32'd0);
        check({tag, " done_cycle"}, 64'(done_c), 64'd45);
        for (int k = 0; k < 16; k++)
            check($sformatf("%s reg%0d", tag, k), {56'd0, rf8[k]}, {56'd0, exp_rf[k][7:0]});
        check({tag, " ovf_final"}, {63'd0, ovf_8}, {63'd0, exp_ovf});
        if (m == 2'b00) begin
            check({tag, " ovf_before_reg11_calc"}, {63'd0, ovf_pre}, 64'd0);
`ifdef SEQ_OVF_DETECT_EN
            check({tag, " ovf_after_reg11_calc"}, {63'd0, ovf_post}, 64'd1);
`else
            check({tag, " ovf_after_reg11_calc"}, {63'd0, ovf_post}, 64'd0);
`endif
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        int          idx;
        logic [31:0] value;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int   n_done, n_busy, abort_c;
        logic [1:0] m;

        vecs[0] = '{2'b00, 2, 32'd2};
        vecs[1] = '{2'b00, 10, 32'd89};
        vecs[2] = '{2'b00, 20, 32'd10946};
        vecs[3] = '{2'b00, 31, 32'd2178309};
        vecs[4] = '{2'b01, 2, 32'd0};
        vecs[5] = '{2'b01, 3, 32'd1};
        vecs[6] = '{2'b01, 4, 32'hFFFF_FFFF};
        vecs[7] = '{2'b01, 5, 32'd2};
        vecs[8] = '{2'b10, 7, 32'd1};
        vecs[9] = '{2'b11, 31, 32'd1};

        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        mode    = 2'b00;
        start_8 = 1'b0;
        abort_8 = 1'b0;
        mode_8  = 2'b00;
        fill32  = 1'b0;
        fill_base = 32'd0;
        repeat (3) @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset ovf", {63'd0, ovf}, 64'd0);
        check("reset rf_we", {63'd0, rf_we}, 64'd0);
        check("reset addrs", {49'd0, rf_raddr1, rf_raddr2, rf_waddr}, 64'd0);
        check("reset wdata", {32'd0, rf_wdata}, 64'd0);
        check("reset alu_ab", {alu_a, alu_b}, 64'd0);
        check("reset alu_op", {62'd0, alu_op}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        n_busy = 0;
        for (int c = 0; c < 4; c++) begin
            if (busy || rf_we) n_busy++;
            @(negedge clk);
        end
        check("start_with_abort_ignored", 64'(n_busy), 64'd0);

        // table-driven full runs
        for (int v = 0; v < 10; v++) begin
            run32(vecs[v].mode, 0, 1'b0, $sformatf("vec%0d", v));
            check($sformatf("vec%0d table reg%0d", v, vecs[v].idx), {32'd0, rf32[vecs[v].idx]}, {32'd0, vecs[v].value});
        end

        // abort during WRITE of i=10 (cycle 29)
        run32(2'b00, 29, 1'b0, "abort_w10");
        check("abort_w10 reg10", {32'd0, rf32[10]}, 64'd89);
        check("abort_w10 reg11_untouched", {32'd0, rf32[11]}, {32'd0, fill_base ^ 32'd11});

        // start re-pulsed during run
        run32(2'b00, 0, 1'b1, "restart_ignored");

        // reset in the READ cycle of i=5
        mode  = 2'b01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("i5 raddr1", {59'd0, rf_raddr1}, 64'd3);
        check("i5 raddr2", {59'd0, rf_raddr2}, 64'd4);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset busy", {63'd0, busy}, 64'd0);
        check("midrun_reset rf_we_done", {62'd0, rf_we, done}, 64'd0);
        check("midrun_reset addrs", {49'd0, rf_raddr1, rf_raddr2, rf_waddr}, 64'd0);
        check("midrun_reset data", {rf_wdata, alu_a | alu_b}, 64'd0);
        check("midrun_reset alu_op", {62'd0, alu_op}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        n_busy = 0;
        for (int c = 0; c < 100; c++) begin
            if (done) n_done++;
            if (busy) n_busy++;
            @(negedge clk);
        end
        check("midrun_reset no_done", 64'(n_done), 64'd0);
        check("midrun_reset stays_idle", 64'(n_busy), 64'd0);

        // randomized runs against the reference model
        for (int r = 0; r < 12; r++) begin
            m       = 2'($urandom);
            abort_c = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 92));
            run32(m, abort_c, 1'b1, $sformatf("rand%0d_m%0d_a%0d", r, m, abort_c));
        end

        // narrow instance: overflow at reg11, held after DONE, cleared by next start
        run8(2'b00, "w8_add");
        repeat (5) @(negedge clk);
        check("w8 ovf_held_after_done", {63'd0, ovf_8}, {63'd0, exp_ovf});
        run8(2'b10, "w8_and");
        run8(2'b01, "w8_sub");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
